inst_loader: RTL and testbench

- Byte-stream program loader that writes 32-bit instruction words into the instruction RAM read by the fetch unit, over the RAM's write port.
- Sits between a host byte source (UART receiver or testbench) and the instruction RAM.
- Asserts cpu_hold while loading, so fetch stays at PC 0 until the program image is complete.

---
 rtl/inst_mem_pkg.sv | 25 ++
 rtl/byte_to_word_asm.sv | 36 +++
 rtl/inst_loader.sv | 143 ++++++++++++++
 tb/tb_inst_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction-RAM loader: FSM encoding, word width,
// default RAM depth and big-endian byte-lane constants.
package inst_mem_pkg;

    localparam int INST_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int NUM_LANES  = INST_W / BYTE_W;
    localparam int DEF_ADDR_W = 6;

    // First byte of a word lands in the top lane (bits 31:24), last in lane 0.
    localparam logic [1:0] LANE_FIRST = 2'd3;
    localparam logic [1:0] LANE_LAST  = 2'd0;
    localparam logic [1:0] LANE_CNT_LAST = 2'(NUM_LANES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WR,
        S_CHK,
        S_FIN,
        S_ABORT
    } state_t;

endpackage

// File: rtl/byte_to_word_asm.sv
// Assembles four stream bytes into one big-endian word; word_full flags the
// cycle in which the fourth byte is accepted (word is valid in that cycle).
module byte_to_word_asm
    import inst_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [INST_W-1:0] word,
    output logic              word_full
);

    logic [INST_W-BYTE_W-1:0] shreg;
    logic [1:0]               lane;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            lane  <= '0;
        end else if (clr) begin
            shreg <= '0;
            lane  <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[INST_W-2*BYTE_W-1:0], byte_in};
            lane  <= lane + 2'd1;
        end
    end

    // The live byte completes the word, so the write can be issued without
    // waiting an extra cycle for the shift to land.
    assign word      = {shreg, byte_in};
    assign word_full = shift_en && (lane == LANE_CNT_LAST);

endmodule

// File: rtl/inst_loader.sv
// Byte-stream loader: count byte N, then N big-endian words written to the
// instruction RAM while cpu_hold is high. `define LOADER_CHECKSUM_EN to require
// a trailing XOR checksum byte over the data bytes.
module inst_loader
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [INST_W-1:0] wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int CNT_W     = ADDR_W + 1;
    localparam int MAX_WORDS = 1 << ADDR_W;

    state_t              state;
    logic [CNT_W-1:0]    n_words;
    logic [CNT_W-1:0]    word_cnt;
    logic [CNT_W-1:0]    next_cnt;
    logic                xfer;
    logic [INST_W-1:0]   asm_word;
    logic                word_full;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign byte_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
    assign xfer       = byte_valid && byte_ready;
    assign next_cnt   = word_cnt + 1'b1;

    byte_to_word_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == S_IDLE),
        .shift_en  (xfer && (state == S_DATA)),
        .byte_in   (byte_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            n_words  <= '0;
            word_cnt <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: if (load_start) begin
                    state    <= S_HDR;
                    cpu_hold <= 1'b1;
                    err      <= 1'b0;
                    word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                    csum     <= '0;
`endif
                end
                S_HDR: if (xfer) begin
                    if (byte_data == 8'd0) begin
                        n_words <= '0;
`ifdef LOADER_CHECKSUM_EN
                        state   <= S_CHK;
`else
                        state   <= S_FIN;
                        done    <= 1'b1;
`endif
                    end else if (int'(byte_data) > MAX_WORDS) begin
                        state <= S_ABORT;
                        err   <= 1'b1;
                    end else begin
                        n_words  <= CNT_W'(byte_data);
                        word_cnt <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    csum <= csum ^ byte_data;
`endif
                    if (word_full) begin
                        we    <= 1'b1;
                        waddr <= word_cnt[ADDR_W-1:0];
                        wdata <= asm_word;
                        state <= S_WR;
                    end
                end
                S_WR: begin
                    word_cnt <= next_cnt;
                    if (next_cnt == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= S_CHK;
`else
                        state <= S_FIN;
                        done  <= 1'b1;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: if (xfer) begin
                    if (byte_data == csum) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ABORT;
                        err   <= 1'b1;
                    end
                end
`endif
                S_FIN, S_ABORT: begin
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: a stream-level model predicts the writes,
// done/err outcome, and a per-cycle monitor compares every RAM write.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    inst_loader #(.ADDR_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  stream[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          obs_addr[0:127];
    logic [31:0] obs_data[0:127];
    int          obs_cnt  = 0;
    int          done_cnt = 0;
    int          mon_ea;
    logic [31:0] mon_ed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Every RAM write must match the next word the model expects.
    always @(negedge clk) begin
        if (rst) begin
            if (we) begin
                if (exp_data.size() == 0) begin
                    chk("unexpected_we", 1, 0);
                end else begin
                    mon_ea = exp_addr.pop_front();
                    mon_ed = exp_data.pop_front();
                    chk("waddr", 64'(waddr), 64'(mon_ea));
                    chk("wdata", 64'(wdata), 64'(mon_ed));
                end
                chk("ready_in_wr", 64'(byte_ready), 0);
                chk("hold_in_wr", 64'(cpu_hold), 1);
                if (obs_cnt < 128) begin
                    obs_addr[obs_cnt] = int'(waddr);
                    obs_data[obs_cnt] = wdata;
                end
                obs_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("hold_at_done", 64'(cpu_hold), 1);
                chk("err_at_done", 64'(err), 0);
            end
        end
    end

    // mode 0: random words, mode 1: word k = k. bad adds 1 to the checksum byte.
    task automatic build(input int n, input int mode, input bit bad);
        logic [7:0]  x;
        logic [31:0] w;
        stream.delete();
        stream.push_back(8'(n));
        x = 8'h00;
        if (n <= 64) begin
            for (int k = 0; k < n; k++) begin
                w = (mode == 1) ? 32'(k) : $urandom;
                for (int b = 3; b >= 0; b--) begin
                    stream.push_back(w[b*8 +: 8]);
                    x ^= w[b*8 +: 8];
                end
            end
`ifdef LOADER_CHECKSUM_EN
            stream.push_back(bad ? x + 8'd1 : x);
`endif
        end
    endtask

    // Model: from the stream alone, queue the expected writes and the outcome.
    task automatic model(output bit ok);
        int         n;
        logic [7:0] x;
        n  = int'(stream[0]);
        ok = (n <= 64);
        x  = 8'h00;
        exp_addr.delete();
        exp_data.delete();
        if (ok) begin
            for (int k = 0; k < n; k++) begin
                exp_addr.push_back(k);
                exp_data.push_back({stream[1+4*k], stream[2+4*k], stream[3+4*k], stream[4+4*k]});
                for (int b = 1; b <= 4; b++) x ^= stream[4*k+b];
            end
`ifdef LOADER_CHECKSUM_EN
            ok = (stream[1+4*n] == x);
`endif
        end
    endtask

    task automatic send(input int lim, input bit mid);
        int idx = 0;
        int cyc = 0;
        bit pend = 0;
        bit fire;
        while (idx < lim && cyc < 4000) begin
            @(negedge clk);
            byte_valid = pend || ($urandom_range(0, 3) != 0);
            byte_data  = stream[idx];
            load_start = mid && (idx > 0) && ($urandom_range(0, 7) == 0);
            fire = byte_valid && byte_ready;
            pend = byte_valid && !fire;
            @(posedge clk);
            if (fire) idx++;
            cyc++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        load_start = 1'b0;
        chk("send_timeout", 64'(idx), 64'(lim));
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("hold_after_start", 64'(cpu_hold), 1);
        chk("err_cleared", 64'(err), 0);
        chk("ready_in_hdr", 64'(byte_ready), 1);
    endtask

    task automatic run_load(input bit mid);
        bit ok;
        int budget;
        model(ok);
        obs_cnt  = 0;
        done_cnt = 0;
        start_load();
        send(stream.size(), mid);
        budget = 0;
        while (cpu_hold && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("hold_release", 64'(cpu_hold), 0);
        chk("done_count", 64'(done_cnt), ok ? 1 : 0);
        chk("err_flag", 64'(err), ok ? 0 : 1);
        chk("writes_left", 64'(exp_data.size()), 0);
        chk("idle_ready", 64'(byte_ready), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 64'(byte_ready), 0);
        chk({tag, "_we"},    64'(we), 0);
        chk({tag, "_waddr"}, 64'(waddr), 0);
        chk({tag, "_wdata"}, 64'(wdata), 0);
        chk({tag, "_hold"},  64'(cpu_hold), 0);
        chk({tag, "_done"},  64'(done), 0);
        chk({tag, "_err"},   64'(err), 0);
    endtask

    initial begin
        bit ok;
        rst = 1'b0; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        // Basic two-word load.
        stream = {8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0);
`endif
        run_load(1'b0);
        chk("basic_cnt",   64'(obs_cnt), 2);
        chk("basic_a0",    64'(obs_addr[0]), 0);
        chk("basic_d0",    64'(obs_data[0]), 64'h12345678);
        chk("basic_a1",    64'(obs_addr[1]), 1);
        chk("basic_d1",    64'(obs_data[1]), 64'h9ABCDEF0);

        // Zero-length and full-size images.
        build(0, 0, 1'b0);
        run_load(1'b0);
        chk("zero_writes", 64'(obs_cnt), 0);
        build(64, 1, 1'b0);
        run_load(1'b0);
        chk("full_cnt",  64'(obs_cnt), 64);
        chk("full_a63",  64'(obs_addr[63]), 63);
        chk("full_d63",  64'(obs_data[63]), 64'h3F);

        // Oversize count aborts; err stays until the next accepted start.
        build(65, 0, 1'b0);
        run_load(1'b0);
        chk("over_writes", 64'(obs_cnt), 0);
        repeat (3) @(negedge clk);
        chk("over_err_sticky", 64'(err), 1);
        build(1, 0, 1'b0);
        run_load(1'b0);

        // Random images with gaps and ignored mid-load starts.
        for (int i = 0; i < 6; i++) begin
            build($urandom_range(1, 12), 0, 1'b0);
            run_load(1'b1);
        end

        // Reset after six data bytes: word 0 already written, word 1 dropped.
        build(2, 0, 1'b0);
        model(ok);
        obs_cnt = 0;
        done_cnt = 0;
        start_load();
        send(7, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        chk("midrst_written", 64'(obs_cnt), 1);
        chk("midrst_pending", 64'(exp_data.size()), 1);
        chk("midrst_done", 64'(done_cnt), 0);
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        rst = 1'b1;
        build(3, 0, 1'b0);
        run_load(1'b0);
        chk("after_rst_a0", 64'(obs_addr[0]), 0);

`ifdef LOADER_CHECKSUM_EN
        stream = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        run_load(1'b0);
        chk("csum_ok_done", 64'(done_cnt), 1);
        stream = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        run_load(1'b0);
        chk("csum_bad_err", 64'(err), 1);
        chk("csum_bad_w0",  64'(obs_data[0]), 64'h11223344);
        build(5, 0, 1'b1);
        run_load(1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
